// File: rtl/divu.sv
// divu: multicycle restoring divider, 33-cycle latency (1 cycle on divide-by-zero).
// Define DIVU_SIGNED_EN to honour the sign input (two's complement operands).
module divu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sign,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, dvs_q, dvs_d, quo_q, quo_d, rmd_q, rmd_d;
   logic [WIDTH-1:0] a_mag, b_mag, fq, fr;
   logic [WIDTH:0] sh, diff;
   logic [4:0] cnt_q, cnt_d;
   logic done_q, done_d, dbz_q, dbz_d;
`ifdef DIVU_SIGNED_EN
   logic nq_q, nr_q;
   always_ff @(posedge clk)
      if (rst) begin
         nq_q <= 1'b0;
         nr_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         nq_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
         nr_q <= sign & a[WIDTH-1];
      end
   assign a_mag = (sign & a[WIDTH-1]) ? -a : a;
   assign b_mag = (sign & b[WIDTH-1]) ? -b : b;
   assign fq = nq_q ? -dvd_q : dvd_q;
   assign fr = nr_q ? -rem_q : rem_q;
`else
   logic unused_sign;
   assign unused_sign = sign;
   assign a_mag = a;
   assign b_mag = b;
   assign fq = dvd_q;
   assign fr = rem_q;
`endif
   always_comb begin
      state_d = state_q;
      dvd_d = dvd_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      quo_d = quo_q;
      rmd_d = rmd_q;
      cnt_d = cnt_q;
      dbz_d = dbz_q;
      done_d = 1'b0;
      sh = {rem_q, dvd_q[WIDTH-1]};
      diff = sh - {1'b0, dvs_q};
      case (state_q)
         IDLE: if (start) begin
            // on divide-by-zero the raw dividend is kept so it can be returned as remainder
            dvd_d = (b == '0) ? a : a_mag;
            dvs_d = b_mag;
            rem_d = '0;
            cnt_d = '0;
            state_d = (b == '0) ? DONE : RUN;
         end
         RUN: begin
            rem_d = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd31) ? DONE : RUN;
         end
         DONE: begin
            dbz_d = (dvs_q == '0);
            quo_d = dbz_d ? '1 : fq;
            rmd_d = dbz_d ? dvd_q : fr;
            done_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         dvd_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         quo_q <= '0;
         rmd_q <= '0;
         cnt_q <= '0;
         dbz_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q <= dvd_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         quo_q <= quo_d;
         rmd_q <= rmd_d;
         cnt_q <= cnt_d;
         dbz_q <= dbz_d;
         done_q <= done_d;
      end
   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign dbz = dbz_q;
   assign quotient = quo_q;
   assign remainder = rmd_q;
endmodule
